id_ex_hazard_reg: RTL and testbench

// - ID/EX pipeline register of the 5-stage MIPS core; sits directly downstream of the Control decoder.
// - Captures the 12-bit control word plus ID-stage operands, and detects load-use hazards.
// - On a hazard or flush it inserts a bubble by zeroing the registered control word.
// - Drives the stall to the PC / IF-ID stage and honours an external pipeline hold.

---
 rtl/id_ex_hazard_reg.sv | 137 +++++++++++++
 tb/tb_id_ex_hazard_reg.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg: ID/EX pipeline register with load-use hazard detection.
// Captures the decoder control word and the ID-stage operands. It inserts a
// bubble (control word zeroed) on a flush, on a flush deferred by hold, or on a
// load-use hazard. It also drives the stall to the PC / IF-ID stage.
// Optional build macro HAZ_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module id_ex_hazard_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic              flush,
   input  logic              hold,
   output logic              stall,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd
`ifdef HAZ_CNT_EN
   ,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       flush_cnt
`endif
);

   // Bit positions inside the control word. RegDst is the MSB. The other
   // fields follow in decoder order.
   localparam int B_REG_DST   = CTRL_W - 1;
   localparam int B_MEM_READ  = CTRL_W - 5;
   localparam int B_MEM_WRITE = CTRL_W - 6;
   localparam int B_BRANCH    = CTRL_W - 7;
   localparam int B_BRANCH1   = CTRL_W - 8;

   logic              flush_pend;
   logic [CTRL_W-1:0] ctrl_clean;
   logic              uses_rt;
   logic              hazard;
   logic              load_en;
   logic              bubble_flush;
   logic              bubble_haz;
   logic [CTRL_W-1:0] ctrl_next;

   // An undriven or unknown decoder bit must never enable an architectural
   // action. Only a definite 1 passes through.
   generate
      for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_clean
         assign ctrl_clean[gi] = (ctrl_in[gi] === 1'b1);
      end
   endgenerate

   // Detect a load in EX whose destination feeds an operand of the ID instruction.
   always_comb begin
      uses_rt = ctrl_clean[B_REG_DST]  | ctrl_clean[B_MEM_WRITE] |
                ctrl_clean[B_BRANCH]   | ctrl_clean[B_BRANCH1];
      hazard  = ex_ctrl[B_MEM_READ] && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
      // A flush squashes the consumer anyway, and a hold freezes everything,
      // so neither case needs the front end held back.
      stall   = rst_n & hazard & ~flush & ~hold;
   end

   // Select what enters EX on the next edge. A flush outranks a hazard bubble.
   always_comb begin
      load_en      = rst_n & ~hold;
      bubble_flush = load_en & (flush | flush_pend);
      bubble_haz   = load_en & ~(flush | flush_pend) & hazard;
      ctrl_next    = (bubble_flush || bubble_haz) ? '0 : ctrl_clean;
   end

   // Control word and deferred flush. A flush seen during hold is remembered
   // and applied on the first free edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_ctrl    <= '0;
         flush_pend <= 1'b0;
      end else if (hold) begin
         if (flush) begin
            flush_pend <= 1'b1;
         end
      end else begin
         ex_ctrl    <= ctrl_next;
         flush_pend <= 1'b0;
      end
   end

   // Operand capture. A bubble still loads the operands, because a zeroed
   // control word makes them harmless.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_pc4 <= '0;
         ex_rd1 <= '0;
         ex_rd2 <= '0;
         ex_imm <= '0;
         ex_rs  <= '0;
         ex_rt  <= '0;
         ex_rd  <= '0;
      end else if (load_en) begin
         ex_pc4 <= id_pc4;
         ex_rd1 <= id_rd1;
         ex_rd2 <= id_rd2;
         ex_imm <= id_imm;
         ex_rs  <= id_rs;
         ex_rt  <= id_rt;
         ex_rd  <= id_rd;
      end
   end

`ifdef HAZ_CNT_EN
   // Saturating bubble counters. They are frozen along with the register during hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (bubble_haz && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
         if (bubble_flush && (flush_cnt != 16'hFFFF)) begin
            flush_cnt <= flush_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// tb_id_ex_hazard_reg: directed scenarios plus a randomized run checked against
// a behavioural model of the ID/EX register. Counter checks are active when
// HAZ_CNT_EN is defined.
module tb_id_ex_hazard_reg;

   logic        clk;
   logic        rst_n;
   logic [11:0] ctrl_in;
   logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        flush, hold;
   logic        stall;
   logic [11:0] ex_ctrl;
   logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [15:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   id_ex_hazard_reg #(.DATA_W(32), .CTRL_W(12)) dut (
      .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in),
      .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .flush(flush), .hold(hold), .stall(stall),
      .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
      .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd)
`ifdef HAZ_CNT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

`ifndef HAZ_CNT_EN
   assign stall_cnt = 16'd0;
   assign flush_cnt = 16'd0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [11:0] c, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      ctrl_in = c;
      id_pc4  = $urandom;
      id_imm  = $urandom;
      id_rd1  = rd1;
      id_rd2  = rd2;
      id_rs   = rs;
      id_rt   = rt;
      id_rd   = rd;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(12'($urandom), $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
         flush = 1'($urandom);
         hold  = 1'($urandom);
         tick();
      end
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
      checks++;
      if ({ex_ctrl, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ctrl=%h pc4=%h rd1=%h rd2=%h imm=%h rs=%0d rt=%0d rd=%0d expected all 0",
                  ex_ctrl, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd);
      end
`ifdef HAZ_CNT_EN
      checks++;
      if ({stall_cnt, flush_cnt} !== 32'd0) begin
         errors++; $display("FAIL reset_counters: got %h/%h expected 0/0", stall_cnt, flush_cnt);
      end
`endif
      rst_n = 1'b1; flush = 1'b0; hold = 1'b0;
   endtask

   task automatic test_pass_through();
      drive(12'h908, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3);
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL pass_stall: got %b expected 0", stall); end
      tick();
      checks++;
      if ({ex_ctrl, ex_rd1, ex_rd2, ex_rd} !== {12'h908, 32'd5, 32'd7, 5'd3}) begin
         errors++;
         $display("FAIL pass_through: got ctrl=%h rd1=%0d rd2=%0d rd=%0d expected 908/5/7/3",
                  ex_ctrl, ex_rd1, ex_rd2, ex_rd);
      end
   endtask

   task automatic test_load_use();
      logic [15:0] s0;
      drive(12'h780, 32'd1, 32'd2, 5'd1, 5'd8, 5'd0);
      tick();
      s0 = stall_cnt;
      drive(12'h908, 32'd11, 32'd12, 5'd8, 5'd2, 5'd4);
      #1;
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b expected 1", stall); end
      tick();
      checks++;
      if (ex_ctrl !== 12'h000) begin errors++; $display("FAIL load_use_bubble: got %h expected 000", ex_ctrl); end
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL load_use_release: got %b expected 0", stall); end
      tick();
      checks++;
      if ({ex_ctrl, ex_rs, ex_rd} !== {12'h908, 5'd8, 5'd4}) begin
         errors++; $display("FAIL load_use_enter: got ctrl=%h rs=%0d rd=%0d expected 908/8/4", ex_ctrl, ex_rs, ex_rd);
      end
`ifdef HAZ_CNT_EN
      checks++;
      if (stall_cnt !== s0 + 16'd1) begin
         errors++; $display("FAIL load_use_cnt: got %0d expected %0d", stall_cnt, s0 + 16'd1);
      end
`endif
   endtask

   task automatic test_rt_zero();
      drive(12'h780, 32'd0, 32'd0, 5'd3, 5'd0, 5'd0);
      tick();
      drive(12'h908, 32'd0, 32'd0, 5'd0, 5'd0, 5'd5);
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL rt_zero_stall: got %b expected 0", stall); end
      tick();
      drive(12'h780, 32'd0, 32'd0, 5'd2, 5'd8, 5'd0);
      tick();
      drive(12'h780, 32'd0, 32'd0, 5'd9, 5'd8, 5'd0);
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL lw_lw_stall: got %b expected 0", stall); end
      tick();
      checks++;
      if (ex_ctrl !== 12'h780) begin errors++; $display("FAIL lw_lw_enter: got %h expected 780", ex_ctrl); end
      // A store reads rt, so a load into its rt must stall.
      drive(12'h440, 32'd0, 32'd0, 5'd1, 5'd8, 5'd0);
      #1;
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL sw_rt_stall: got %b expected 1", stall); end
      tick();
      checks++;
      if (ex_ctrl !== 12'h000) begin errors++; $display("FAIL sw_rt_bubble: got %h expected 000", ex_ctrl); end
      tick();
      checks++;
      if (ex_ctrl !== 12'h440) begin errors++; $display("FAIL sw_rt_enter: got %h expected 440", ex_ctrl); end
   endtask

   task automatic test_flush_vs_hazard();
      logic [15:0] s0, f0;
      drive(12'h780, 32'd0, 32'd0, 5'd1, 5'd8, 5'd0);
      tick();
      s0 = stall_cnt; f0 = flush_cnt;
      drive(12'h908, 32'd21, 32'd22, 5'd8, 5'd2, 5'd6);
      flush = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL flush_haz_stall: got %b expected 0", stall); end
      tick();
      flush = 1'b0;
      checks++;
      if ({ex_ctrl, ex_rd1} !== {12'h000, 32'd21}) begin
         errors++; $display("FAIL flush_haz_bubble: got ctrl=%h rd1=%0d expected 000/21", ex_ctrl, ex_rd1);
      end
`ifdef HAZ_CNT_EN
      checks++;
      if ({stall_cnt, flush_cnt} !== {s0, f0 + 16'd1}) begin
         errors++; $display("FAIL flush_haz_cnt: got %0d/%0d expected %0d/%0d", stall_cnt, flush_cnt, s0, f0 + 16'd1);
      end
`endif
      tick();
      checks++;
      if (ex_ctrl !== 12'h908) begin errors++; $display("FAIL flush_haz_after: got %h expected 908", ex_ctrl); end
   endtask

   task automatic test_hold_flush();
      logic [15:0] f0;
      f0 = flush_cnt;
      drive(12'h123, 32'd99, 32'd98, 5'd4, 5'd5, 5'd6);
      hold = 1'b1; flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (stall !== 1'b0) begin errors++; $display("FAIL hold_stall: got %b expected 0", stall); end
         tick();
         checks++;
         if ({ex_ctrl, ex_rd1} !== {12'h908, 32'd21}) begin
            errors++; $display("FAIL hold_frozen: got ctrl=%h rd1=%0d expected 908/21", ex_ctrl, ex_rd1);
         end
      end
      hold = 1'b0; flush = 1'b0;
      tick();
      checks++;
      if ({ex_ctrl, ex_rd1} !== {12'h000, 32'd99}) begin
         errors++; $display("FAIL hold_release_bubble: got ctrl=%h rd1=%0d expected 000/99", ex_ctrl, ex_rd1);
      end
      tick();
      checks++;
      if (ex_ctrl !== 12'h123) begin errors++; $display("FAIL hold_single_bubble: got %h expected 123", ex_ctrl); end
`ifdef HAZ_CNT_EN
      checks++;
      if (flush_cnt !== f0 + 16'd1) begin
         errors++; $display("FAIL hold_flush_cnt: got %0d expected %0d", flush_cnt, f0 + 16'd1);
      end
`endif
   endtask

   task automatic test_reset_mid();
      drive(12'h908, 32'd1, 32'd1, 5'd1, 5'd1, 5'd1);
      hold = 1'b1; flush = 1'b1;
      tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if ({ex_ctrl, ex_rd1} !== 44'd0) begin
         errors++; $display("FAIL reset_mid: got ctrl=%h rd1=%0d expected 0/0", ex_ctrl, ex_rd1);
      end
      rst_n = 1'b1; hold = 1'b0; flush = 1'b0;
      drive(12'h908, 32'd3, 32'd3, 5'd1, 5'd1, 5'd1);
      tick();
      checks++;
      if (ex_ctrl !== 12'h908) begin errors++; $display("FAIL reset_clears_pend: got %h expected 908", ex_ctrl); end
   endtask

   // The reference model tracks what EX holds, using the pipeline rules directly.
   task automatic test_random();
      logic [11:0] m_ctrl;
      logic [31:0] m_pc4, m_rd1, m_rd2, m_imm;
      logic [4:0]  m_rs, m_rt, m_rd;
      logic        m_pend;
      int          m_scnt, m_fcnt;
      logic        load_in_ex, reads_rt, hz, exp_stall;
      rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
      tick();
      rst_n = 1'b1;
      m_ctrl = 0; m_pc4 = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_rd = 0;
      m_pend = 0; m_scnt = 0; m_fcnt = 0;
      for (int n = 0; n < 400; n++) begin
         drive(12'($urandom), $urandom, $urandom, 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom));
         if ($urandom_range(0, 9) < 4) ctrl_in[7] = 1'b1;
         hold  = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 7) == 0);
         rst_n = ($urandom_range(0, 31) != 0);
         load_in_ex = m_ctrl[7];
         reads_rt   = ctrl_in[11] | ctrl_in[6] | ctrl_in[5] | ctrl_in[4];
         hz = load_in_ex && (m_rt != 0) && ((m_rt == id_rs) || (reads_rt && (m_rt == id_rt)));
         exp_stall = rst_n && hz && !flush && !hold;
         #1;
         checks++;
         if (stall !== exp_stall) begin
            errors++; $display("FAIL rand_stall[%0d]: got %b expected %b", n, stall, exp_stall);
         end
         if (!rst_n) begin
            m_ctrl = 0; m_pc4 = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_rd = 0;
            m_pend = 0; m_scnt = 0; m_fcnt = 0;
         end else if (hold) begin
            if (flush) m_pend = 1;
         end else begin
            m_pc4 = id_pc4; m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            if (flush || m_pend) begin
               m_ctrl = 0; m_pend = 0;
               if (m_fcnt < 65535) m_fcnt++;
            end else if (hz) begin
               m_ctrl = 0;
               if (m_scnt < 65535) m_scnt++;
            end else begin
               m_ctrl = ctrl_in;
            end
         end
         tick();
         checks++;
         if ({ex_ctrl, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd} !==
             {m_ctrl, m_pc4, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_rd}) begin
            errors++;
            $display("FAIL rand_regs[%0d]: got ctrl=%h pc4=%h rd1=%h rd2=%h imm=%h rs=%0d rt=%0d rd=%0d expected ctrl=%h pc4=%h rd1=%h rd2=%h imm=%h rs=%0d rt=%0d rd=%0d",
                     n, ex_ctrl, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd,
                     m_ctrl, m_pc4, m_rd1, m_rd2, m_imm, m_rs, m_rt, m_rd);
         end
`ifdef HAZ_CNT_EN
         checks++;
         if ({stall_cnt, flush_cnt} !== {16'(m_scnt), 16'(m_fcnt)}) begin
            errors++;
            $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", n, stall_cnt, flush_cnt, m_scnt, m_fcnt);
         end
`endif
      end
      rst_n = 1'b1; hold = 1'b0; flush = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
      drive(12'h000, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
      test_reset();
      test_pass_through();
      test_load_use();
      test_rt_zero();
      test_flush_vs_hazard();
      test_hold_flush();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
